text_line_fetch: RTL
====================

TEXT_LINE_FETCH -- requirements
Module: text_line_fetch

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- COLS, 80, text columns per row; legal range 1..128.
- ASCII_WIDTH, 7, character code width.
- ADDR_WIDTH, 11, font ROM address width.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; every register in the block is clocked by it.
- rst_n, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle pulse that starts a scanline fetch.
- line_cnt, in, 4, glyph row (0..10) within the character cell; sampled on an accepted start.
- txt_rd, out, 1, text buffer read strobe.
- txt_addr, out, 7, text buffer column address.
- txt_data, in, ASCII_WIDTH, character code; valid the cycle after txt_rd.
- dec_ascii, out, ASCII_WIDTH, character code driven to the external combinational glyph-address decoder.
- dec_line, out, 4, glyph row driven to the decoder.
- font_rd, out, 1, font ROM read strobe; the ROM address comes from the decoder.
- font_data, in, 8, glyph row pixels; valid the cycle after font_rd.
- lb_we, out, 1, line buffer write enable.
- lb_addr, out, 7, line buffer column address.
- lb_data, out, 8, line buffer write data.
- busy, out, 1, high from the accepted start to the final write, inclusive.
- done, out, 1, one-cycle pulse the cycle after the final write.

Function
REQ-003 FSM states: IDLE, TXT, LATCH, FONT, WR, FIN.
REQ-004 IDLE: start=1 latches line_cnt into line_q, sets col=0 and moves to TXT. A start in any other state is ignored.
REQ-005 TXT: txt_rd=1 and txt_addr=col; next state is LATCH.
REQ-006 LATCH: txt_data is captured into ascii_q; next state is FONT.
REQ-007 FONT: font_rd=1, dec_ascii=ascii_q, dec_line=line_q; next state is WR.
REQ-008 WR: lb_we=1, lb_addr=col, lb_data=font_data. If col==COLS-1 the next state is FIN; otherwise col increments and the next state is TXT.
REQ-009 FIN: done=1; next state is IDLE.
REQ-010 Timing: each column takes exactly 4 cycles. The first txt_rd occurs the cycle after start. done asserts 4*COLS+1 cycles after start.
REQ-011 dec_ascii and dec_line hold their last values outside FONT. txt_addr and lb_addr equal col in every state.
REQ-012 If line_q>10, lb_data=8'h00 for every column and font_rd stays 0. All other sequencing and timing are unchanged.
REQ-013 txt_rd, font_rd and lb_we are each high only in their own state; they are never high simultaneously.
REQ-014 Character code range handling belongs to the decoder; the block passes codes through unmodified.
REQ-015 col is 7 bits and never exceeds COLS-1; it does not wrap.

Reset
REQ-016 While rst_n=0 at a clk edge: state=IDLE; col, ascii_q and line_q clear to 0; all strobes, busy and done are 0; dec_ascii, dec_line, txt_addr, lb_addr and lb_data are 0.
REQ-017 A reset during a fetch aborts it immediately; no further writes occur and done is not pulsed.
REQ-018 start is ignored in any cycle where rst_n=0.

Configuration
REQ-019 Macro TEXT_CURSOR_EN defined:
- Ports cursor_col (in, 7) and cursor_on (in, 1) exist.
- In WR, when cursor_on=1 and col==cursor_col, lb_data is the bitwise inverse of its REQ-008/REQ-012 value.
REQ-020 Macro TEXT_CURSOR_EN undefined: both cursor ports are absent and lb_data follows REQ-008/REQ-012 only.

Verification
REQ-021 Reset, then start with line_cnt=3, COLS=80 -> first txt_rd one cycle later; 80 lb_we pulses with lb_addr 0..79; done at cycle 321 after start; busy falls with done.
REQ-022 Text col 5 holds 7'h41, ROM model returns 8'h18 for decoder address (65-32)*11+3=366 -> write at lb_addr=5 with lb_data=8'h18.
REQ-023 start pulsed again at cycle 10 of a fetch -> ignored; exactly 80 writes occur and a single done pulse.
REQ-024 line_cnt=12 -> 80 writes of 8'h00 and no font_rd assertions.
REQ-025 rst_n low for 1 cycle at cycle 50 -> no lb_we after reset, no done pulse; a following start runs a complete fresh fetch from col 0.
REQ-026 TEXT_CURSOR_EN defined, cursor_on=1, cursor_col=7, font byte 8'h3C at col 7 -> lb_data=8'hC3 at lb_addr=7; all other columns are uninverted.

Source files
------------

// File: rtl/text_line_fetch.sv
// Scanline fetch engine: walks a text row column by column, reads each character,
// looks up one glyph row via an external decoder/ROM and writes the pixels into a
// line buffer. Optional cursor inversion is enabled by defining TEXT_CURSOR_EN.
module text_line_fetch #(
    parameter int COLS        = 80,
    parameter int ASCII_WIDTH = 7,
    parameter int ADDR_WIDTH  = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             line_cnt,
    output logic                   txt_rd,
    output logic [6:0]             txt_addr,
    input  logic [ASCII_WIDTH-1:0] txt_data,
    output logic [ASCII_WIDTH-1:0] dec_ascii,
    output logic [3:0]             dec_line,
    output logic                   font_rd,
    input  logic [7:0]             font_data,
    output logic                   lb_we,
    output logic [6:0]             lb_addr,
    output logic [7:0]             lb_data,
    output logic                   busy,
    output logic                   done
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [6:0]             cursor_col,
    input  logic                   cursor_on
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TXT   = 3'd1,
        LATCH = 3'd2,
        FONT  = 3'd3,
        WR    = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [3:0] MAX_ROW  = 4'd10;

    generate
        if (COLS < 1 || COLS > 128 || ASCII_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_cfg
            $error("text_line_fetch: illegal parameter setting");
        end
    endgenerate

    state_t                 state_r;
    state_t                 next_state_s;
    logic [6:0]             col_r;
    logic [3:0]             line_r;
    logic [ASCII_WIDTH-1:0] dec_ascii_r;
    logic [3:0]             dec_line_r;
    logic                   txt_rd_r;
    logic                   font_rd_r;
    logic                   lb_we_r;
    logic                   busy_r;
    logic                   done_r;
    logic [7:0]             pix_s;

    // Next-state sequencing: four cycles per column, one FIN cycle at the end.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = TXT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            TXT:   next_state_s = LATCH;
            LATCH: next_state_s = FONT;
            FONT:  next_state_s = WR;
            WR: begin
                if (col_r == LAST_COL) begin
                    next_state_s = FIN;
                end else begin
                    next_state_s = TXT;
                end
            end
            FIN:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register and strobes, registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            txt_rd_r  <= 1'b0;
            font_rd_r <= 1'b0;
            lb_we_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            txt_rd_r  <= (next_state_s == TXT);
            // Rows past the glyph height never touch the ROM.
            font_rd_r <= (next_state_s == FONT) && (line_r <= MAX_ROW);
            lb_we_r   <= (next_state_s == WR);
            busy_r    <= (next_state_s == TXT) || (next_state_s == LATCH) ||
                         (next_state_s == FONT) || (next_state_s == WR);
            done_r    <= (next_state_s == FIN);
        end
    end

    // Datapath: column counter, latched glyph row and the decoder-facing character.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r       <= 7'd0;
            line_r      <= 4'd0;
            dec_ascii_r <= '0;
            dec_line_r  <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        line_r <= line_cnt;
                        col_r  <= 7'd0;
                    end else begin
                        line_r <= line_r;
                        col_r  <= col_r;
                    end
                end
                LATCH: begin
                    dec_ascii_r <= txt_data;
                    dec_line_r  <= line_r;
                end
                WR: begin
                    if (col_r != LAST_COL) begin
                        col_r <= col_r + 7'd1;
                    end else begin
                        col_r <= col_r;
                    end
                end
                default: begin
                    col_r <= col_r;
                end
            endcase
        end
    end

    // Write data comes straight from the ROM, which answers in the WR cycle.
    always_comb begin
        pix_s = 8'h00;
        if (line_r > MAX_ROW) begin
            pix_s = 8'h00;
        end else begin
            pix_s = font_data;
        end
`ifdef TEXT_CURSOR_EN
        if (cursor_on && (col_r == cursor_col)) begin
            pix_s = ~pix_s;
        end else begin
            pix_s = pix_s;
        end
`endif
        if (state_r == WR) begin
            lb_data = pix_s;
        end else begin
            lb_data = 8'h00;
        end
    end

    assign txt_rd    = txt_rd_r;
    assign txt_addr  = col_r;
    assign dec_ascii = dec_ascii_r;
    assign dec_line  = dec_line_r;
    assign font_rd   = font_rd_r;
    assign lb_we     = lb_we_r;
    assign lb_addr   = col_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
